// File: rtl/cond_exec_controller.sv
// Conditional-execution controller at the issue point.
//
// Owns the architectural status register {z,c,n,v}, tracks in-flight
// flag-setting instructions and holds back condition-dependent issue until
// their flags have been written. A flag write in the same cycle is forwarded
// straight into condition evaluation. Each accepted instruction yields a
// registered execute/squash decision one cycle later for the EXE stage.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   issue_valid/cond/s   instruction presented by ID (cond field, S bit)
//   issue_ready          combinational accept; accept = issue_valid && issue_ready
//   flag_wr_en/data      write-back of one pending flag result {z,c,n,v}
//   flush                kill all younger in-flight instructions
//   status               current status register {z,c,n,v}
//   dec_valid/dec_exec   registered decision (1 = execute, 0 = squash)
//   err_wr               sticky: flag write seen with nothing pending
//   stall_cnt            saturating count of stall cycles
module cond_exec_controller #(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned PCNT_W      = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [3:0]             issue_cond,
  input  logic                   issue_s,
  output logic                   issue_ready,
  input  logic                   flag_wr_en,
  input  logic [3:0]             flag_wr_data,
  input  logic                   flush,
  output logic [3:0]             status,
  output logic                   dec_valid,
  output logic                   dec_exec,
  output logic                   err_wr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [3:0] CondAl = 4'b1110;

  state_e                 state_q, state_d;
  logic [3:0]             status_q, status_d;
  logic [PCNT_W-1:0]      pending_q, pending_d;
  logic                   dec_valid_q, dec_valid_d;
  logic                   dec_exec_q, dec_exec_d;
  logic                   err_wr_q, err_wr_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [3:0] flags_fwd;
  logic       dependent;
  logic       hazard;
  logic       full_block;
  logic       accept;
  logic       cond_true;
  logic       pend_inc;
  logic       pend_dec;
  logic       stalling;

  // Flags are packed {z,c,n,v}.
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = !z;
      4'b0010: eval_cond = c;
      4'b0011: eval_cond = !c;
      4'b0100: eval_cond = n;
      4'b0101: eval_cond = !n;
      4'b0110: eval_cond = v;
      4'b0111: eval_cond = !v;
      4'b1000: eval_cond = c && !z;
      4'b1001: eval_cond = !c || z;
      4'b1010: eval_cond = (n == v);
      4'b1011: eval_cond = (n != v);
      4'b1100: eval_cond = !z && (n == v);
      4'b1101: eval_cond = z || (n != v);
      4'b1110: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  always_comb begin
    flags_fwd = flag_wr_en ? flag_wr_data : status_q;
    dependent = (issue_cond != CondAl);
    // A single outstanding writer is fine if its write lands this cycle (forwarded).
    hazard = dependent &&
             ((pending_q > PCNT_W'(1)) || ((pending_q == PCNT_W'(1)) && !flag_wr_en));
    // A retiring write frees a slot in the same cycle, so a full counter need not block.
    full_block  = issue_s && (pending_q == PCNT_W'(MAX_PENDING)) && !flag_wr_en;
    issue_ready = !hazard && !full_block && !flush;
    accept      = issue_valid && issue_ready;
    cond_true   = eval_cond(issue_cond, flags_fwd);
    stalling    = issue_valid && !issue_ready && !flush;
    // Only an executed S instruction becomes a pending writer.
    pend_inc    = accept && issue_s && cond_true;
    pend_dec    = flag_wr_en && (pending_q != '0);
  end

  always_comb begin
    status_d    = status_q;
    pending_d   = pending_q;
    err_wr_d    = err_wr_q;
    stall_cnt_d = stall_cnt_q;
    dec_valid_d = accept;
    dec_exec_d  = accept && cond_true;

    // Writes belong to older instructions and commit even during flush.
    if (flag_wr_en) begin
      status_d = flag_wr_data;
      if (pending_q == '0) begin
        err_wr_d = 1'b1;
      end
    end

    if (flush) begin
      pending_d = '0;
    end else begin
      case ({pend_inc, pend_dec})
        2'b10:   pending_d = pending_q + PCNT_W'(1);
        2'b01:   pending_d = pending_q - PCNT_W'(1);
        default: pending_d = pending_q;
      endcase
    end

    if (stalling && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (stalling) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (accept || !issue_valid || flush) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      status_q    <= '0;
      pending_q   <= '0;
      dec_valid_q <= 1'b0;
      dec_exec_q  <= 1'b0;
      err_wr_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      pending_q   <= pending_d;
      dec_valid_q <= dec_valid_d;
      dec_exec_q  <= dec_exec_d;
      err_wr_q    <= err_wr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign status    = status_q;
  assign dec_valid = dec_valid_q;
  assign dec_exec  = dec_exec_q;
  assign err_wr    = err_wr_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cond_exec_controller.sv
module tb_cond_exec_controller;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_cond;
  logic        issue_s;
  logic        issue_ready;
  logic        flag_wr_en;
  logic [3:0]  flag_wr_data;
  logic        flush;
  logic [3:0]  status;
  logic        dec_valid;
  logic        dec_exec;
  logic        err_wr;
  logic [15:0] stall_cnt;

  int checks;
  int failures;
  bit sb[$];

  cond_exec_controller #(
    .MAX_PENDING(3),
    .PCNT_W     (2),
    .STALL_CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_cond  (issue_cond),
    .issue_s     (issue_s),
    .issue_ready (issue_ready),
    .flag_wr_en  (flag_wr_en),
    .flag_wr_data(flag_wr_data),
    .flush       (flush),
    .status      (status),
    .dec_valid   (dec_valid),
    .dec_exec    (dec_exec),
    .err_wr      (err_wr),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decision monitor: registered outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dec_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_decision got dec_valid=1 exec=%0b required no decision", dec_exec);
      end else begin
        bit exp;
        exp = sb.pop_front();
        if (dec_exec !== exp) begin
          failures++;
          $display("FAIL decision got dec_exec=%0b required %0b", dec_exec, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_cond   = 4'b0000;
    issue_s      = 1'b0;
    flag_wr_en   = 1'b0;
    flag_wr_data = 4'b0000;
    flush        = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one instruction expected to be accepted this cycle.
  task automatic issue_ok(input logic [3:0] cond, input logic s, input bit exp, input string nm);
    issue_valid = 1'b1;
    issue_cond  = cond;
    issue_s     = s;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got %0b required 1", nm, issue_ready);
    end
    sb.push_back(exp);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    checks++; if (status !== 4'b0000) begin failures++; $display("FAIL rst_status got %0h required 0", status); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got %0b required 0", dec_valid); end
    checks++; if (dec_exec !== 1'b0) begin failures++; $display("FAIL rst_dec_exec got %0b required 0", dec_exec); end
    checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL rst_err_wr got %0b required 0", err_wr); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got %0d required 0", stall_cnt); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %0b required 1", issue_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    apply_reset();
    // EQ with z=0: squash, no pending change.
    issue_ok(4'b0000, 1'b0, 1'b0, "basic_eq");
    checks++; if (dut.pending_q !== 2'd0) begin failures++; $display("FAIL basic_pending got %0d required 0", dut.pending_q); end
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    issue_ok(4'b1110, 1'b1, 1'b1, "stall_al");
    issue_valid = 1'b1; issue_cond = 4'b0000; issue_s = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL stall_ready1 got %0b required 0", issue_ready); end
    tick();
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL stall_ready2 got %0b required 0", issue_ready); end
    tick();
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt got %0d required 2", stall_cnt); end
    checks++; if (dut.state_q !== 1'b1) begin failures++; $display("FAIL stall_state got %0b required 1", dut.state_q); end
    // Write lands: forwarded z=1 resolves EQ as execute.
    flag_wr_en = 1'b1; flag_wr_data = 4'b1000;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL stall_fwd_ready got %0b required 1", issue_ready); end
    sb.push_back(1'b1);
    tick();
    idle();
    checks++; if (status !== 4'b1000) begin failures++; $display("FAIL stall_status got %0h required 8", status); end
    checks++; if (dut.pending_q !== 2'd0) begin failures++; $display("FAIL stall_pending got %0d required 0", dut.pending_q); end
    checks++; if (dut.state_q !== 1'b0) begin failures++; $display("FAIL stall_state_run got %0b required 0", dut.state_q); end
    checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL stall_err got %0b required 0", err_wr); end
    tick();
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_cond = 4'b1110; issue_s = 1'b1;
      #1;
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got %0b required 1", i, issue_ready); end
      sb.push_back(1'b1);
      tick();
    end
    checks++; if (dut.pending_q !== 2'd3) begin failures++; $display("FAIL full_pending3 got %0d required 3", dut.pending_q); end
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL full_block got %0b required 0", issue_ready); end
    tick();
    flag_wr_en = 1'b1; flag_wr_data = 4'b0000;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL full_wr_ready got %0b required 1", issue_ready); end
    sb.push_back(1'b1);
    tick();
    idle();
    checks++; if (dut.pending_q !== 2'd3) begin failures++; $display("FAIL full_pending_hold got %0d required 3", dut.pending_q); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL full_stall_cnt got %0d required 1", stall_cnt); end
    tick();
  endtask

  // Sweep all 16 conditions back to back against a fixed status.
  task automatic sweep(input logic [3:0] flags, input logic [15:0] table_exp, input string nm);
    issue_ok(4'b1110, 1'b1, 1'b1, "sweep_setup");
    flag_wr_en = 1'b1; flag_wr_data = flags;
    tick();
    idle();
    checks++; if (status !== flags) begin failures++; $display("FAIL %s_status got %0h required %0h", nm, status, flags); end
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_cond = 4'(i); issue_s = 1'b0;
      #1;
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_c%0d got %0b required 1", nm, i, issue_ready); end
      sb.push_back(table_exp[i]);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_cond();
    apply_reset();
    // c=1, z=0: LS (!c||z) squashes.
    issue_ok(4'b1110, 1'b1, 1'b1, "cond_setup");
    flag_wr_en = 1'b1; flag_wr_data = 4'b0100;
    tick();
    idle();
    issue_ok(4'b1001, 1'b0, 1'b0, "cond_ls_false");
    issue_ok(4'b1110, 1'b1, 1'b1, "cond_setup2");
    flag_wr_en = 1'b1; flag_wr_data = 4'b1100;
    tick();
    idle();
    issue_ok(4'b1001, 1'b0, 1'b1, "cond_ls_true");
    sweep(4'b1100, 16'h66A5, "sweep_zc");
    sweep(4'b0011, 16'h565A, "sweep_nv");
    checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL cond_err got %0b required 0", err_wr); end
  endtask

  task automatic test_flush();
    apply_reset();
    issue_ok(4'b1110, 1'b1, 1'b1, "flush_al0");
    issue_ok(4'b1110, 1'b1, 1'b1, "flush_al1");
    checks++; if (dut.pending_q !== 2'd2) begin failures++; $display("FAIL flush_pending2 got %0d required 2", dut.pending_q); end
    flush = 1'b1; flag_wr_en = 1'b1; flag_wr_data = 4'b0110;
    issue_valid = 1'b1; issue_cond = 4'b1110; issue_s = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %0b required 0", issue_ready); end
    tick();
    idle();
    checks++; if (dut.pending_q !== 2'd0) begin failures++; $display("FAIL flush_pending got %0d required 0", dut.pending_q); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL flush_dec_valid got %0b required 0", dec_valid); end
    checks++; if (status !== 4'b0110) begin failures++; $display("FAIL flush_status got %0h required 6", status); end
    checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL flush_err0 got %0b required 0", err_wr); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL flush_stall_cnt got %0d required 0", stall_cnt); end
    flag_wr_en = 1'b1; flag_wr_data = 4'b0001;
    tick();
    idle();
    checks++; if (err_wr !== 1'b1) begin failures++; $display("FAIL flush_err1 got %0b required 1", err_wr); end
    checks++; if (status !== 4'b0001) begin failures++; $display("FAIL flush_status2 got %0h required 1", status); end
    checks++; if (dut.pending_q !== 2'd0) begin failures++; $display("FAIL flush_pending_zero got %0d required 0", dut.pending_q); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    for (int i = 0; i < 3; i++) issue_ok(4'b1110, 1'b1, 1'b1, "rms_al");
    flag_wr_en = 1'b1; flag_wr_data = 4'b1010;
    tick();
    idle();
    issue_valid = 1'b1; issue_cond = 4'b0000; issue_s = 1'b0;
    tick();
    tick();
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL rms_stall_cnt got %0d required 2", stall_cnt); end
    checks++; if (dut.pending_q !== 2'd2) begin failures++; $display("FAIL rms_pending got %0d required 2", dut.pending_q); end
    checks++; if (dut.state_q !== 1'b1) begin failures++; $display("FAIL rms_state got %0b required 1", dut.state_q); end
    checks++; if (status !== 4'b1010) begin failures++; $display("FAIL rms_status_pre got %0h required a", status); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (status !== 4'b0000) begin failures++; $display("FAIL rms_status got %0h required 0", status); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rms_stall_rst got %0d required 0", stall_cnt); end
    checks++; if (dut.pending_q !== 2'd0) begin failures++; $display("FAIL rms_pending_rst got %0d required 0", dut.pending_q); end
    checks++; if (dut.state_q !== 1'b0) begin failures++; $display("FAIL rms_state_rst got %0b required 0", dut.state_q); end
    checks++; if (dec_valid !== 1'b0 || dec_exec !== 1'b0 || err_wr !== 1'b0) begin
      failures++;
      $display("FAIL rms_outs got valid=%0b exec=%0b err=%0b required 0 0 0", dec_valid, dec_exec, err_wr);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_cond();
    test_flush();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d outstanding decisions required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_exec_controller.md
Name: cond_exec_controller

Overview:
- Sequences conditional execution at the issue point of the core.
- Owns the architectural status register, packed {z,c,n,v} in bits [3:0].
- Tracks in-flight flag-setting instructions and stalls condition-dependent issue until flags resolve. A same-cycle flag write is forwarded directly into the condition evaluation.
- Emits a registered execute/squash decision per accepted instruction, for the EXE stage.

Parameters:
- MAX_PENDING, default 3: maximum outstanding flag writers (S=1, executed, flags not yet written).
- PCNT_W, default 2: width of the pending counter; must satisfy 2^PCNT_W > MAX_PENDING.
- STALL_CNT_W, default 16: width of the saturating stall performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID stage presents an instruction.
- issue_cond  in  4  condition field of the presented instruction.
- issue_s  in  1  presented instruction updates flags when executed.
- issue_ready  out  1  combinational; instruction accepted when issue_valid && issue_ready.
- flag_wr_en  in  1  write-back of one pending flag result this cycle.
- flag_wr_data  in  4  new {z,c,n,v}.
- flush  in  1  kill all younger in-flight instructions.
- status  out  4  current status register {z,c,n,v}.
- dec_valid  out  1  registered; a decision is present this cycle.
- dec_exec  out  1  registered; 1 = execute, 0 = squash (valid with dec_valid).
- err_wr  out  1  sticky: flag write seen while pending == 0.
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0) values: status=0000, pending=0, state=RUN, dec_valid=0, dec_exec=0, err_wr=0, stall_cnt=0.
- Condition evaluation on flags F:
  - 0000 z; 0001 !z; 0010 c; 0011 !c; 0100 n; 0101 !n; 0110 v; 0111 !v.
  - 1000 c&&!z; 1001 !c||z; 1010 n==v; 1011 n!=v.
  - 1100 !z&&(n==v); 1101 z||(n!=v); 1110 always true; 1111 false.
- Forwarding: F = flag_wr_data when flag_wr_en, else status.
- Hazard: cond != 1110 is flag-dependent. hazard = dependent && (pending > 1 || (pending == 1 && !flag_wr_en)).
- issue_ready = !hazard && !(issue_s && pending == MAX_PENDING && !flag_wr_en) && !flush.
- Accept, at the next edge: dec_valid=1 and dec_exec=eval(issue_cond,F). With no accept, dec_valid=0. Latency is 1 cycle.
- Pending counter:
  - +1 when the accepted instruction has issue_s && eval true.
  - -1 on flag_wr_en.
  - Both in the same cycle leaves it unchanged.
  - A squashed S instruction never increments.
- Status register: loads flag_wr_data on flag_wr_en.
- Flag write while pending == 0 (including a write after flush): status still updates, pending stays 0, err_wr sets (cleared only by reset).
- flush:
  - Next edge: pending=0 and dec_valid=0.
  - A same-cycle flag_wr_en still commits to status; it belongs to an older instruction.
  - No accept occurs in a flush cycle.
- FSM:
  - RUN -> STALL when issue_valid && !issue_ready && !flush.
  - STALL -> RUN on an accept, or when issue_valid drops, or on flush.
  - stall_cnt increments each cycle that issue_valid && !issue_ready && !flush, saturating at all-ones.
- Counter never wraps: increment at MAX_PENDING is blocked by issue_ready; decrement at 0 is blocked per the err_wr rule.

Test Plan:
- Reset released, status=0000, issue cond=0000 (EQ), issue_s=0 -> issue_ready=1; next cycle dec_valid=1, dec_exec=0; pending stays 0.
- Issue cond=1110 with S=1, then issue cond=0000 the next cycle, flag_wr_en low for 2 cycles -> second instruction stalls 2 cycles; stall_cnt=2; STALL state.
  - On cycle 3, flag_wr_en=1 with flag_wr_data=1000 forwarded -> accepted; dec_exec=1; status=1000; pending=0.
- Three S=1 AL issues back to back with no writes -> pending=3; fourth S issue has issue_ready=0.
  - Assert flag_wr_en once -> fourth accepted the same cycle; pending stays 3.
- Cond=1001 with status c=1, z=0 -> dec_exec=0. With status=1100 (z=1, c=1) -> dec_exec=1.
- pending=2, flush and flag_wr_en(0110) asserted together -> pending=0, dec_valid=0, status=0110.
  - Subsequent flag_wr_en -> err_wr=1.
- rst_n pulsed low mid-stall with pending=2 -> immediately: all outputs at reset values, state RUN, stall_cnt=0.
